// File: rtl/uart7n_frame_tx_if.sv
// Word-side handshake bundle for uart7n_frame_tx: 7-bit word with valid/ready.
interface uart7n_frame_tx_if;
  logic [6:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart7n_frame_tx.sv
// 7-bit UART frame serialiser: start, 7 data LSB first, optional parity, 1/2 stop bits.
// Optional 4-entry input FIFO when UART7N_TX_FIFO_EN is defined.
module uart7n_frame_tx #(
  parameter int unsigned p_clk_speed_hz = 50_000_000,
  parameter int unsigned p_baud_rate    = 9_600
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               parity_en_i,
  input  logic               parity_sel_i,
  input  logic               stop_sel_i,
  uart7n_frame_tx_if.slave   word_if,
  output logic               data_o,
  output logic               busy_o,
  output logic               sent_o
);

  localparam int unsigned DIV = p_clk_speed_hz / p_baud_rate;
  localparam int unsigned CW  = $clog2(DIV);

  typedef struct packed {
    logic [6:0] data;
    logic       par_en;
    logic       par_sel;
    logic       stop_sel;
  } frame_cfg_t;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  frame_cfg_t      cfg_q, cfg_d;
  logic            line_q, line_d;
  logic            busy_q, busy_d;
  logic            sent_q, sent_d;

  frame_cfg_t      in_word;
  frame_cfg_t      src_word;
  logic            can_start;
  logic            start_c;
  logic            last_bit;

  assign in_word   = '{word_if.data, parity_en_i, parity_sel_i, stop_sel_i};
  // sent_q marks the final clock of the last stop bit, where a new frame may chain on
  assign can_start = (state_q == S_IDLE) | sent_q;

`ifdef UART7N_TX_FIFO_EN
  frame_cfg_t  mem_q [4];
  frame_cfg_t  mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        push, pop;

  assign word_if.ready = (count_q != 3'd4);
  assign push          = word_if.valid & word_if.ready;
  assign pop           = enable_i & can_start & (count_q != 3'd0);
  assign start_c       = pop;
  assign src_word      = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_word;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    count_d = count_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end
`else
  logic ready_c;

  assign ready_c       = enable_i & can_start;
  assign word_if.ready = ready_c;
  assign start_c       = word_if.valid & ready_c;
  assign src_word      = in_word;
`endif

  // Next-state and registered line outputs
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    cfg_d    = cfg_q;
    last_bit = (baud_q == CW'(DIV - 1));

    if (state_q == S_IDLE) begin
      if (start_c) begin
        state_d = S_START;
        cfg_d   = src_word;
        baud_d  = '0;
      end
    end else if (!last_bit) begin
      baud_d = baud_q + CW'(1);
    end else begin
      baud_d = '0;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          bit_d   = '0;
        end
        S_DATA: begin
          if (bit_q == 3'd6) state_d = cfg_q.par_en ? S_PARITY : S_STOP1;
          else               bit_d   = bit_q + 3'd1;
        end
        S_PARITY: state_d = S_STOP1;
        S_STOP1, S_STOP2: begin
          if (state_q == S_STOP1 && cfg_q.stop_sel) begin
            state_d = S_STOP2;
          end else if (start_c) begin
            state_d = S_START;
            cfg_d   = src_word;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = cfg_d.data[bit_d];
      S_PARITY: line_d = (^cfg_d.data) ^ cfg_d.par_sel;
      default:  line_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
    sent_d = ((state_d == S_STOP1 && !cfg_d.stop_sel) || state_d == S_STOP2) &&
             (baud_d == CW'(DIV - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      cfg_q   <= '0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      cfg_q   <= cfg_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
    end
  end

  assign data_o = line_q;
  assign busy_o = busy_q;
  assign sent_o = sent_q;

endmodule
